// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared types and helpers for the integer-to-float datapath.
//               Provides the rounding-mode encoding, the exponent bias helper
//               and the default float format width (bfloat16).
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

  typedef enum logic {
    RM_RNE = 1'b0,
    RM_RTZ = 1'b1
  } rm_e;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 7;
  localparam int FP_W     = 1 + FP_EXP_W + FP_MAN_W;

  // IEEE-style bias: 2^(exp_w-1) - 1
  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ============================================================================
// Module      : fp_lzc
// Description : Combinational leading-zero counter.
// Revision    : 1.0 - initial release
// Ports       : vec      in  WIDTH     vector to scan
//               count    out CNT_W     number of leading zeros (WIDTH if zero)
//               all_zero out 1         vec is entirely zero
// ============================================================================
module fp_lzc #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CNT_W-1:0] count,
  output logic             all_zero
);

  // Scan upward; the highest set bit is seen last and therefore wins.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

  assign all_zero = ~|vec;

endmodule
`default_nettype wire

// File: rtl/int_to_fp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : int_to_fp_pipe
// Description : Three-stage pipelined integer-to-float converter with
//               valid/ready handshake on both sides. S1 sign/magnitude,
//               S2 normalise, S3 round (RNE/RTZ) and pack.
// Revision    : 1.0 - initial release
// Macro       : INT_TO_FP_INEXACT_EN - adds the registered inexact_o flag
// Ports       : clk_i        in  1          clock
//               rst_i        in  1          async active-high reset
//               in_valid_i   in  1          operand valid
//               in_ready_o   out 1          operand accepted this cycle
//               int_i        in  INT_W      integer operand
//               signed_i     in  1          1: two's complement operand
//               rm_i         in  1          0: RNE, 1: RTZ
//               out_valid_o  out 1          result valid
//               out_ready_i  in  1          downstream accepts result
//               fp_o         out 1+E+M      {sign, exponent, mantissa}
//               inexact_o    out 1          result rounded (macro only)
// ============================================================================
module int_to_fp_pipe #(
  parameter int INT_W = 32,
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [INT_W-1:0]         int_i,
  input  logic                     signed_i,
  input  logic                     rm_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [EXP_W+MAN_W:0]     fp_o
`ifdef INT_TO_FP_INEXACT_EN
  ,
  output logic                     inexact_o
`endif
);

  import fp_pkg::*;

  localparam int LZW   = $clog2(INT_W) + 1;
  // Exponent path: wide enough for bias + INT_W + carry without wrapping.
  localparam int XW    = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
  localparam int EXT_W = INT_W - 1 + MAN_W + 2;
  localparam logic [XW-1:0]    BIAS     = XW'(fp_bias(EXP_W));
  localparam logic [XW-1:0]    EXP_MAX  = XW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [MAN_W-1:0] MAN_ONES = '1;

  // ---------------- handshake ----------------
  logic s1_valid, s2_valid, s3_valid;
  logic s1_adv, s2_adv, s3_adv;

  assign s3_adv      = out_ready_i | ~s3_valid;
  assign s2_adv      = ~s2_valid | s3_adv;
  assign s1_adv      = ~s1_valid | s2_adv;
  assign in_ready_o  = ~s1_valid | s1_adv;
  assign out_valid_o = s3_valid;

  // ---------------- S1: sign / magnitude ----------------
  logic             in_neg;
  logic [INT_W-1:0] in_mag;
  logic             s1_sign, s1_zero;
  logic [INT_W-1:0] s1_mag;
  rm_e              s1_rm;

  assign in_neg = signed_i & int_i[INT_W-1];
  // Unsigned negate: the most negative value maps to 2^(INT_W-1) naturally.
  assign in_mag = in_neg ? (INT_W'(0) - int_i) : int_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
      s1_rm    <= RM_RNE;
      s1_zero  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid_i;
      if (in_valid_i) begin
        s1_sign <= in_neg;
        s1_mag  <= in_mag;
        s1_rm   <= rm_e'(rm_i);
        s1_zero <= (in_mag == '0);
      end
    end
  end

  // ---------------- S2: normalise ----------------
  logic [LZW-1:0]   s1_lz;
  logic             s1_all_zero;
  logic             norm_hidden;
  logic [INT_W-2:0] norm_frac;
  logic [XW-1:0]    exp_unb;

  fp_lzc #(.WIDTH(INT_W)) u_lzc (
    .vec      (s1_mag),
    .count    (s1_lz),
    .all_zero (s1_all_zero)
  );

  assign {norm_hidden, norm_frac} = s1_mag << s1_lz;
  assign exp_unb = s1_all_zero ? '0 : (XW'(INT_W - 1) - XW'(s1_lz));

  logic             s2_sign, s2_zero;
  logic [INT_W-2:0] s2_frac;
  logic [XW-1:0]    s2_exp;
  rm_e              s2_rm;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_frac  <= '0;
      s2_exp   <= '0;
      s2_rm    <= RM_RNE;
      s2_zero  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_sign;
        s2_frac <= norm_frac;
        s2_exp  <= exp_unb;
        s2_rm   <= s1_rm;
        // A clear hidden bit after normalising can only mean a zero operand.
        s2_zero <= s1_zero | ~norm_hidden;
      end
    end
  end

  // ---------------- S3: round and pack ----------------
  // Zero-padding below the fraction keeps slicing legal for any INT_W/MAN_W
  // pair; narrow integers simply see guard = sticky = 0.
  logic [EXT_W-1:0]   ext;
  logic [MAN_W-1:0]   mant;
  logic               guard, sticky, round_up, ovf;
  logic [MAN_W:0]     mant_sum;
  logic [XW-1:0]      exp_b;
  logic [EXP_W+MAN_W:0] res;

  assign ext      = {s2_frac, {(MAN_W + 2){1'b0}}};
  assign mant     = ext[EXT_W-1 -: MAN_W];
  assign guard    = ext[EXT_W-1-MAN_W];
  assign sticky   = |ext[EXT_W-2-MAN_W:0];
  assign round_up = (s2_rm == RM_RNE) & guard & (sticky | mant[0]);
  assign mant_sum = {1'b0, mant} + (MAN_W + 1)'(round_up);
  assign exp_b    = s2_exp + BIAS + XW'(mant_sum[MAN_W]);
  assign ovf      = (exp_b >= EXP_MAX);

  always_comb begin
    res = '0;
    if (!s2_zero) begin
      if (ovf) begin
        if (s2_rm == RM_RNE) res = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
        else                 res = {s2_sign, EXP_ONES - EXP_W'(1), MAN_ONES};
      end else begin
        res = {s2_sign, exp_b[EXP_W-1:0], mant_sum[MAN_W-1:0]};
      end
    end
  end

  logic [EXP_W+MAN_W:0] fp_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s3_valid <= 1'b0;
      fp_q     <= '0;
    end else if (s3_adv) begin
      s3_valid <= s2_valid;
      if (s2_valid) fp_q <= res;
    end
  end

  assign fp_o = fp_q;

`ifdef INT_TO_FP_INEXACT_EN
  logic res_inexact, ix_q;

  assign res_inexact = ~s2_zero & (guard | sticky | ovf);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ix_q <= 1'b0;
    end else if (s3_adv && s2_valid) begin
      ix_q <= res_inexact;
    end
  end

  assign inexact_o = ix_q;
`endif

endmodule
`default_nettype wire
